// File: rtl/pipelined_subtractor_if.sv
// Valid/ready operand and result bundle for the pipelined subtractor.
// The master drives operands and result acceptance; the slave is the datapath.
interface pipelined_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow, zero
    );
endinterface

// File: rtl/pipelined_subtractor.sv
// Two-stage a - b datapath: low half plus carry in stage 1, high half
// and flags in stage 2, with valid/ready flow control between stages.
module pipelined_subtractor #(
    parameter int WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_subtractor_if.slave bus
);
    localparam int H = WIDTH / 2;

    typedef struct packed {
        logic [H-1:0] lo;
        logic         c;
        logic [H-1:0] a_hi;
        logic [H-1:0] b_hi;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             overflow;
        logic             zero;
    } s2_t;

    s1_t        s1_q;
    s1_t        s1_d;
    s2_t        s2_q;
    s2_t        s2_d;
    logic       s1_valid;
    logic       s2_valid;
    logic       s2_adv;
    logic       in_xfer;
    logic [H:0] lo_sum;
    logic [H:0] hi_sum;

    assign s2_adv      = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | s2_adv;
    assign in_xfer     = bus.in_valid & bus.in_ready;

    // a + ~b + 1 on the low half; the +1 is the initial carry-in
    always_comb begin
        lo_sum = {1'b0, bus.a[H-1:0]}
               + {1'b0, ~bus.b[H-1:0]}
               + {{H{1'b0}}, 1'b1};
        s1_d.lo   = lo_sum[H-1:0];
        s1_d.c    = lo_sum[H];
        s1_d.a_hi = bus.a[WIDTH-1:H];
        s1_d.b_hi = bus.b[WIDTH-1:H];
    end

    always_comb begin
        hi_sum = {1'b0, s1_q.a_hi}
               + {1'b0, ~s1_q.b_hi}
               + {{H{1'b0}}, s1_q.c};
        s2_d.diff     = {hi_sum[H-1:0], s1_q.lo};
        s2_d.borrow   = ~hi_sum[H];
        s2_d.overflow = (s1_q.a_hi[H-1] ^ s1_q.b_hi[H-1])
                      & (s1_q.a_hi[H-1] ^ hi_sum[H-1]);
        s2_d.zero     = ~|{hi_sum[H-1:0], s1_q.lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_valid <= in_xfer | (s1_valid & ~s2_adv);
            if (in_xfer) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            s2_valid <= s2_adv | (s2_valid & ~bus.out_ready);
            if (s2_adv) begin
                s2_q <= s2_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.diff      = s2_q.diff;
    assign bus.borrow    = s2_q.borrow;
    assign bus.overflow  = s2_q.overflow;
    assign bus.zero      = s2_q.zero;
endmodule
